// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// It handles three kinds of event:
//   - load-use bubbles;
//   - a multicycle-unit freeze, with a timeout abort;
//   - a taken-branch flush.
// It also drains the pipeline into a held state on a halt request.
// All pipeline control outputs are combinational from state and inputs.
module pipeline_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int DRAIN_CYC  = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_mc_start,
    input  logic             mc_done,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             halted,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter runs 0..MC_TIMEOUT-1 while in MC_WAIT.
    localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    // Drain counter holds the number of bubbles already issued, 1..DRAIN_CYC-1.
    localparam int DRN_W  = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_RUN,
        S_MC_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load_use;

    // The ID instruction needs the value that the load in EX has not produced yet.
    assign load_use = id_ex_MemRead && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    assign mc_timeout   = timeout_q;
    assign stall_cycles = stall_q;

    // Next-state and pipeline control decode; defaults let the pipeline flow.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    // Wrong-path instructions in IF and ID are squashed; PC takes the target.
                    // A branch that is also an mc op is treated as a branch.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_ex_mc_start) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_hold     = 1'b1;
                    wait_d      = '0;
                    state_d     = S_MC_WAIT;
                end else if (halt_req) begin
                    // This cycle already issues the first drain bubble.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    drain_d      = DRN_W'(1);
                    state_d      = (DRAIN_CYC <= 1) ? S_HALTED : S_DRAIN;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            S_MC_WAIT: begin
                if (mc_done) begin
                    // Holds released so EX/MEM captures the result this cycle.
                    state_d = S_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_hold     = 1'b1;
                    wait_d      = wait_q + WAIT_W'(1);
                end
            end
            S_DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (drain_q == DRN_LAST) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
                if (!halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        stall_d = (!pc_write && (stall_q != CNT_MAX)) ? (stall_q + CNT_W'(1)) : stall_q;
    end

    // State, counters and the sticky timeout flag; reset returns to RUN with everything cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            drain_q   <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// A cycle-level reference model, written from the behavioural rules, predicts every output.
// Two DUT copies share the stimulus; the second has a 4-bit stall counter to exercise saturation.
module tb_pipeline_hazard_ctrl;

    localparam int MCT = 4;
    localparam int DRC = 3;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic           clk;
    logic           rst_n;
    logic [4:0]     if_id_rs, if_id_rt, id_ex_rt;
    logic           if_id_uses_rt, id_ex_MemRead, id_ex_mc_start, mc_done, branch_taken, halt_req;

    logic           a_pc, a_ifw, a_fl, a_bub, a_hold, a_halt, a_to;
    logic [CW-1:0]  a_stall;
    logic           b_pc, b_ifw, b_fl, b_bub, b_hold, b_halt, b_to;
    logic [CWS-1:0] b_stall;

    pipeline_hazard_ctrl #(.MC_TIMEOUT(MCT), .DRAIN_CYC(DRC), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt), .id_ex_mc_start(id_ex_mc_start),
        .mc_done(mc_done), .branch_taken(branch_taken), .halt_req(halt_req),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl), .id_ex_bubble(a_bub),
        .ex_hold(a_hold), .halted(a_halt), .mc_timeout(a_to), .stall_cycles(a_stall)
    );

    pipeline_hazard_ctrl #(.MC_TIMEOUT(MCT), .DRAIN_CYC(DRC), .CNT_W(CWS)) u_b (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt), .id_ex_mc_start(id_ex_mc_start),
        .mc_done(mc_done), .branch_taken(branch_taken), .halt_req(halt_req),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl), .id_ex_bubble(b_bub),
        .ex_hold(b_hold), .halted(b_halt), .mc_timeout(b_to), .stall_cycles(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: mode 0 running, 1 waiting on the mc unit, 2 draining, 3 halted.
    int m_mode, m_age, m_bub, m_stalls;
    bit m_to;
    int nx_mode, nx_age, nx_bub, nx_stalls;
    bit nx_to;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_bub = 0; m_stalls = 0; m_to = 1'b0;
    endtask

    task automatic model_eval();
        bit lu;
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_halt = 0;
        nx_mode = m_mode; nx_age = m_age; nx_bub = m_bub; nx_to = m_to;
        lu = id_ex_MemRead && (id_ex_rt != 0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
        case (m_mode)
            0: begin
                if (branch_taken) begin
                    e_fl = 1; e_bub = 1;
                end else if (id_ex_mc_start) begin
                    e_pc = 0; e_ifw = 0; e_hold = 1;
                    nx_mode = 1; nx_age = 1;
                end else if (halt_req) begin
                    e_pc = 0; e_ifw = 0; e_bub = 1;
                    nx_bub = 1;
                    nx_mode = (nx_bub >= DRC) ? 3 : 2;
                end else if (lu) begin
                    e_pc = 0; e_ifw = 0; e_bub = 1;
                end
            end
            1: begin
                // m_age = cycles since the op entered EX; the abort comes MCT cycles after entry.
                if (mc_done) begin
                    nx_mode = 0;
                end else if (m_age >= MCT) begin
                    nx_to = 1; nx_mode = 0;
                end else begin
                    e_pc = 0; e_ifw = 0; e_hold = 1;
                    nx_age = m_age + 1;
                end
            end
            2: begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
                nx_bub = m_bub + 1;
                if (nx_bub >= DRC) nx_mode = 3;
            end
            default: begin
                e_pc = 0; e_ifw = 0; e_bub = 1; e_halt = 1;
                if (!halt_req) nx_mode = 0;
            end
        endcase
        nx_stalls = m_stalls + (e_pc ? 0 : 1);
    endtask

    task automatic check_all();
        chk("pc_write",       a_pc,    e_pc);
        chk("if_id_write",    a_ifw,   e_ifw);
        chk("if_id_flush",    a_fl,    e_fl);
        chk("id_ex_bubble",   a_bub,   e_bub);
        chk("ex_hold",        a_hold,  e_hold);
        chk("halted",         a_halt,  e_halt);
        chk("mc_timeout",     a_to,    m_to);
        chk("stall_cycles",   a_stall, sat(m_stalls, CW));
        chk("b_pc_write",     b_pc,    e_pc);
        chk("b_if_id_write",  b_ifw,   e_ifw);
        chk("b_if_id_flush",  b_fl,    e_fl);
        chk("b_id_ex_bubble", b_bub,   e_bub);
        chk("b_ex_hold",      b_hold,  e_hold);
        chk("b_halted",       b_halt,  e_halt);
        chk("b_mc_timeout",   b_to,    m_to);
        chk("b_stall_sat",    b_stall, sat(m_stalls, CWS));
    endtask

    task automatic set_in(input bit br, input bit ms, input bit md, input bit hr, input bit mr,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                          input bit urt);
        branch_taken = br; id_ex_mc_start = ms; mc_done = md; halt_req = hr;
        id_ex_MemRead = mr; if_id_rs = rs; if_id_rt = rt; id_ex_rt = ert; if_id_uses_rt = urt;
    endtask

    // One clock cycle: drive at negedge, check after settling, advance the model at posedge.
    task automatic step(input bit br, input bit ms, input bit md, input bit hr, input bit mr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                        input bit urt);
        @(negedge clk);
        set_in(br, ms, md, hr, mr, rs, rt, ert, urt);
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        m_mode = nx_mode; m_age = nx_age; m_bub = nx_bub; m_to = nx_to; m_stalls = nx_stalls;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // Asserts reset between clock edges and checks the cleared outputs right away.
    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_all();
        chk("rst_pc_write_async", a_pc, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit hr_lvl;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        model_reset();
        do_reset();

        // Load-use on rs, then the load has moved on.
        step(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        step(0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 0);
        // Load to r0 never stalls; rt match without uses_rt does not stall; with it, stalls.
        step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        step(0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd5, 0);
        step(0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd5, 1);
        // Branch together with load-use: flush wins, no stall counted.
        step(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0);
        // Branch together with an mc start is treated as a branch.
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);

        // Multicycle op at t (mc_done at t ignored), done at t+3.
        step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);

        // Branch, halt and load-use ignored during MC_WAIT; the pending halt is taken afterwards.
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 1, 1, 5'd3, 5'd0, 5'd3, 0);
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);

        // Timeout with no done: sticky until reset.
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(6);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);

        // One-cycle halt pulse, then halt held a while.
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(6);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);

        // Reset in the middle of MC_WAIT.
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);
        do_reset();
        idle(1);

        // Continuous load-use stalls drive the narrow counter into saturation.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd7, 0);
        idle(1);

        // Randomized traffic with occasional resets.
        hr_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) hr_lvl = ~hr_lvl;
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 hr_lvl, $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
